// File: rtl/assert_mon_pkg.sv
// Shared types and constants for the checker result monitor.
// The state enum and the "no failure seen" timestamp marker.
package assert_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ALARM  = 2'd2,
        REPORT = 2'd3
    } mon_state_e;

    localparam int TS_MAX_W = 64;

    // Callers cast this down to their own timestamp width.
    function automatic logic [TS_MAX_W-1:0] ts_none();
        return '1;
    endfunction

endpackage

// File: rtl/assert_result_monitor_sat_counter.sv
// Up-counter that holds at MAX instead of wrapping; clr has priority over inc.
module sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/assert_result_monitor.sv
// Accumulates checker pass/fail statistics over an armed window, raises a
// consecutive-fail alarm and hands out one summary record per window.
module assert_result_monitor
    import assert_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    parameter int FAIL_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             chk_valid,
    input  logic             match,
    input  logic             fail,
    output logic             busy,
    output logic             alarm,
    output logic             proto_err,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_pass_cnt,
    output logic [CNT_W-1:0] rpt_fail_cnt,
    output logic [TS_W-1:0]  rpt_first_fail_ts,
    output logic             rpt_alarm
);

    localparam logic [TS_W-1:0]  TS_NONE   = TS_W'(ts_none());
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(FAIL_LIMIT);
    localparam logic [CNT_W:0]   LIMIT_EXT = (CNT_W+1)'(FAIL_LIMIT);

    typedef struct packed {
        logic [CNT_W-1:0] pass;
        logic [CNT_W-1:0] fail;
        logic [TS_W-1:0]  first_ts;
        logic             alarm;
    } rpt_t;

    mon_state_e       state_q, state_d;
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  first_ts_q, first_ts_d;
    logic             alarm_q, alarm_d;
    logic             perr_q, perr_d;

    logic             win, sample, clear;
    logic             pass_s, fail_s, perr_s, limit_hit;
    logic [CNT_W-1:0] pass_val, fail_val, consec_val;
    rpt_t             rpt;

    // A start without stop re-arms, so the sample on that cycle is dropped.
    always_comb begin
        win       = (state_q == ARMED) || (state_q == ALARM);
        sample    = win && chk_valid && !(start && !stop);
        pass_s    = sample && match && !fail;
        fail_s    = sample && fail && !match;
        perr_s    = sample && (match == fail);
        limit_hit = fail_s && (({1'b0, consec_val} + 1'b1) >= LIMIT_EXT);
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    clear   = 1'b1;
                end
            end
            ARMED, ALARM: begin
                if (stop)
                    state_d = REPORT;
                else if (start) begin
                    state_d = ARMED;
                    clear   = 1'b1;
                end else if (limit_hit)
                    state_d = ALARM;
            end
            REPORT: begin
                if (rpt_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alarm_d    = alarm_q | limit_hit;
        perr_d     = perr_q | perr_s;
        first_ts_d = first_ts_q;
        if (fail_s && (fail_val == '0))
            first_ts_d = ts_q;
        if (clear) begin
            alarm_d    = 1'b0;
            perr_d     = 1'b0;
            first_ts_d = TS_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            first_ts_q <= TS_NONE;
            alarm_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + 1'b1;
            first_ts_q <= first_ts_d;
            alarm_q    <= alarm_d;
            perr_q     <= perr_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (pass_s),
        .value (pass_val)
    );

    sat_counter #(.W(CNT_W)) u_fail (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (fail_s),
        .value (fail_val)
    );

    // Run length of back-to-back fails; a pass breaks the run.
    sat_counter #(.W(CNT_W), .MAX(LIMIT)) u_consec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear | pass_s),
        .inc   (fail_s),
        .value (consec_val)
    );

    always_comb begin
        rpt = '{pass: '0, fail: '0, first_ts: TS_NONE, alarm: 1'b0};
        if (state_q == REPORT)
            rpt = '{pass: pass_val, fail: fail_val, first_ts: first_ts_q, alarm: alarm_q};
    end

    assign busy              = win;
    assign alarm             = alarm_q;
    assign proto_err         = perr_q;
    assign rpt_valid         = (state_q == REPORT);
    assign rpt_pass_cnt      = rpt.pass;
    assign rpt_fail_cnt      = rpt.fail;
    assign rpt_first_fail_ts = rpt.first_ts;
    assign rpt_alarm         = rpt.alarm;

endmodule
